// File: rtl/ula_pkg.sv
// Shared types and constants for the 8-bit bitwise logic-unit scheduler.
package ula_pkg;

    localparam int unsigned LARGURA_DADO    = 8;
    localparam int unsigned CICLOS_EXEC_MAX = 4;
    localparam int unsigned LARGURA_CONT    = $clog2(CICLOS_EXEC_MAX);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_ula_t;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        EXECUTA  = 2'b01,
        RESPONDE = 2'b10
    } estado_t;

    // Operation captured at grant time and held while it executes.
    typedef struct packed {
        op_ula_t                 op;
        logic [LARGURA_DADO-1:0] a;
        logic [LARGURA_DADO-1:0] b;
        logic                    id;
    } operacao_t;

endpackage

// File: rtl/nucleo_logico_8bits.sv
// Combinational 8-bit bitwise core: AND, OR, XOR, NOT a (b ignored for NOT).
module nucleo_logico_8bits
    import ula_pkg::*;
(
    input  op_ula_t                 op,
    input  logic [LARGURA_DADO-1:0] a,
    input  logic [LARGURA_DADO-1:0] b,
    output logic [LARGURA_DADO-1:0] s
);

    always_comb begin
        s = '0;
        unique case (op)
            OP_AND:  s = a & b;
            OP_OR:   s = a | b;
            OP_XOR:  s = a ^ b;
            OP_NOT:  s = ~a;
            default: s = '0;
        endcase
    end

endmodule

// File: rtl/escalonador_ula_8bits.sv
// Two-requester scheduler in front of the 8-bit bitwise core (idle/execute/respond).
// Define ESCALONADOR_PRIORIDADE_FIXA_EN to make requester 0 always win ties.
module escalonador_ula_8bits
    import ula_pkg::*;
#(
    parameter int unsigned CICLOS_EXEC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [1:0]              req0_op,
    input  logic [LARGURA_DADO-1:0] req0_a,
    input  logic [LARGURA_DADO-1:0] req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [1:0]              req1_op,
    input  logic [LARGURA_DADO-1:0] req1_a,
    input  logic [LARGURA_DADO-1:0] req1_b,
    output logic                    resp_valid,
    output logic                    resp_id,
    output logic [LARGURA_DADO-1:0] resp_s,
    input  logic                    resp_ready,
    output logic                    ocupado
);

    if (CICLOS_EXEC == 0 || CICLOS_EXEC > CICLOS_EXEC_MAX) begin : g_ciclos_invalido
        $error("CICLOS_EXEC out of range 1..%0d", CICLOS_EXEC_MAX);
    end

    localparam logic [LARGURA_CONT-1:0] ULTIMO_CICLO = LARGURA_CONT'(CICLOS_EXEC - 1);

    estado_t                 estado_q, estado_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    operacao_t               oper_q, oper_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_id_q, resp_id_d;
    logic [LARGURA_DADO-1:0] resp_s_q, resp_s_d;
    logic                    ocupado_q, ocupado_d;
    logic [LARGURA_DADO-1:0] s_nucleo;
    logic                    escolhe1;

`ifndef ESCALONADOR_PRIORIDADE_FIXA_EN
    // ptr_q high means requester 1 wins the next tie.
    logic ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    nucleo_logico_8bits u_nucleo (
        .op (oper_q.op),
        .a  (oper_q.a),
        .b  (oper_q.b),
        .s  (s_nucleo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            cont_q       <= '0;
            oper_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_s_q     <= '0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cont_q       <= cont_d;
            oper_q       <= oper_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_s_q     <= resp_s_d;
            ocupado_q    <= ocupado_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        cont_d       = cont_q;
        oper_d       = oper_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_s_d     = resp_s_q;
        ocupado_d    = ocupado_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
`ifdef ESCALONADOR_PRIORIDADE_FIXA_EN
        escolhe1     = req1_valid && !req0_valid;
`else
        ptr_d        = ptr_q;
        escolhe1     = req1_valid && (!req0_valid || ptr_q);
`endif

        unique case (estado_q)
            OCIOSO: begin
                // rst_n gate keeps both readies low while reset is held.
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready = !escolhe1;
                    req1_ready = escolhe1;
                    if (escolhe1) begin
                        oper_d.op = op_ula_t'(req1_op);
                        oper_d.a  = req1_a;
                        oper_d.b  = req1_b;
                        oper_d.id = 1'b1;
                    end else begin
                        oper_d.op = op_ula_t'(req0_op);
                        oper_d.a  = req0_a;
                        oper_d.b  = req0_b;
                        oper_d.id = 1'b0;
                    end
`ifndef ESCALONADOR_PRIORIDADE_FIXA_EN
                    ptr_d     = !escolhe1;
`endif
                    cont_d    = '0;
                    ocupado_d = 1'b1;
                    estado_d  = EXECUTA;
                end
            end
            EXECUTA: begin
                if (cont_q == ULTIMO_CICLO) begin
                    cont_d       = '0;
                    resp_s_d     = s_nucleo;
                    resp_id_d    = oper_q.id;
                    resp_valid_d = 1'b1;
                    estado_d     = RESPONDE;
                end else begin
                    cont_d = cont_q + LARGURA_CONT'(1);
                end
            end
            RESPONDE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    ocupado_d    = 1'b0;
                    estado_d     = OCIOSO;
                end
            end
            default: begin
                cont_d       = '0;
                resp_valid_d = 1'b0;
                ocupado_d    = 1'b0;
                estado_d     = OCIOSO;
            end
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_s     = resp_s_q;
    assign ocupado    = ocupado_q;

endmodule

// File: tb/tb_escalonador_ula_8bits.sv
// Bench for escalonador_ula_8bits: directed scenarios plus random traffic vs a cycle-level reference.
module tb_escalonador_ula_8bits;

    localparam int unsigned CICLOS_A = 1;
    localparam int unsigned CICLOS_B = 4;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       resp_valid, resp_id, resp_ready, ocupado;
    logic [7:0] resp_s;

    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [1:0] b_req0_op, b_req1_op;
    logic [7:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
    logic       b_resp_valid, b_resp_id, b_resp_ready, b_ocupado;
    logic [7:0] b_resp_s;

    int errors = 0;
    int checks = 0;

    escalonador_ula_8bits #(.CICLOS_EXEC(CICLOS_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_s(resp_s),
        .resp_ready(resp_ready), .ocupado(ocupado)
    );

    escalonador_ula_8bits #(.CICLOS_EXEC(CICLOS_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
        .req0_a(b_req0_a), .req0_b(b_req0_b),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
        .req1_a(b_req1_a), .req1_b(b_req1_b),
        .resp_valid(b_resp_valid), .resp_id(b_resp_id), .resp_s(b_resp_s),
        .resp_ready(b_resp_ready), .ocupado(b_ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a scheduler that is either free, busy for a known number of cycles, or holding a response.
    typedef enum int {M_LIVRE, M_EXEC, M_RESP} fase_t;
    fase_t      m_fase;
    int         m_restam;
    int         m_ultimo;
    logic [7:0] m_pend_s, m_s;
    logic       m_pend_id, m_id;

    logic       o_r0, o_r1, o_rv, o_id;
    logic [7:0] o_s;

    logic [7:0] d_s [3];
    logic       d_id [3];

    function automatic logic [7:0] ula_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic int vencedor();
        if (m_fase != M_LIVRE) return -1;
        if (req0_valid && req1_valid) begin
`ifdef ESCALONADOR_PRIORIDADE_FIXA_EN
            return 0;
`else
            return (m_ultimo == 0) ? 1 : 0;
`endif
        end
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic modelo_reset();
        m_fase   = M_LIVRE;
        m_restam = 0;
        m_ultimo = 1;
        m_s      = 8'h00;
        m_id     = 1'b0;
        m_pend_s = 8'h00;
        m_pend_id = 1'b0;
    endtask

    task automatic avanca_modelo(input int w);
        case (m_fase)
            M_LIVRE: begin
                if (w >= 0) begin
                    m_pend_s  = (w == 0) ? ula_ref(req0_op, req0_a, req0_b)
                                         : ula_ref(req1_op, req1_a, req1_b);
                    m_pend_id = (w == 1);
                    m_ultimo  = w;
                    m_restam  = CICLOS_A;
                    m_fase    = M_EXEC;
                end
            end
            M_EXEC: begin
                m_restam--;
                if (m_restam == 0) begin
                    m_fase = M_RESP;
                    m_s    = m_pend_s;
                    m_id   = m_pend_id;
                end
            end
            default: begin
                if (resp_ready) m_fase = M_LIVRE;
            end
        endcase
    endtask

    // Called at posedge+1 with inputs already driven; checks, steps the model, returns at next posedge+1.
    task automatic ciclo();
        int w;
        #2;
        w    = vencedor();
        o_r0 = req0_ready;
        o_r1 = req1_ready;
        o_rv = resp_valid;
        o_id = resp_id;
        o_s  = resp_s;
        confere("ready0", 32'(req0_ready), 32'(w == 0));
        confere("ready1", 32'(req1_ready), 32'(w == 1));
        confere("resp_valid", 32'(resp_valid), 32'(m_fase == M_RESP));
        confere("ocupado", 32'(ocupado), 32'(m_fase != M_LIVRE));
        confere("resp_s", 32'(resp_s), 32'(m_s));
        confere("resp_id", 32'(resp_id), 32'(m_id));
        avanca_modelo(w);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int g0;
        int lat;

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0; req0_op = 2'd0; req1_op = 2'd0;
        req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00; resp_ready = 1'b0;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_op = 2'd0; b_req1_op = 2'd0;
        b_req0_a = 8'h00; b_req0_b = 8'h00; b_req1_a = 8'h00; b_req1_b = 8'h00; b_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_s[i]  = 8'h00;
            d_id[i] = 1'b0;
        end
        modelo_reset();

        repeat (2) @(posedge clk);
        #1;
        confere("rst_ready0", 32'(req0_ready), 32'd0);
        confere("rst_resp_valid", 32'(resp_valid), 32'd0);
        confere("rst_resp_s", 32'(resp_s), 32'h00);
        confere("rst_resp_id", 32'(resp_id), 32'd0);
        confere("rst_ocupado", 32'(ocupado), 32'd0);
        confere("b_rst_resp_valid", 32'(b_resp_valid), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous requesters; requester 0 reissues once after its first grant.
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'hFF; req0_b = 8'h3C;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'hFF; req1_b = 8'h3C;
        resp_ready = 1'b1;
        n  = 0;
        g0 = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            ciclo();
            if (o_rv) begin
                d_s[n]  = o_s;
                d_id[n] = o_id;
                n++;
            end
            if (o_r0) begin
                g0++;
                if (g0 >= 2) req0_valid = 1'b0;
            end
            if (o_r1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        confere("d28_count", 32'(n), 32'd3);
`ifdef ESCALONADOR_PRIORIDADE_FIXA_EN
        confere("d28_id0", 32'(d_id[0]), 32'd0); confere("d28_s0", 32'(d_s[0]), 32'h3C);
        confere("d28_id1", 32'(d_id[1]), 32'd0); confere("d28_s1", 32'(d_s[1]), 32'h3C);
        confere("d28_id2", 32'(d_id[2]), 32'd1); confere("d28_s2", 32'(d_s[2]), 32'hC3);
`else
        confere("d28_id0", 32'(d_id[0]), 32'd0); confere("d28_s0", 32'(d_s[0]), 32'h3C);
        confere("d28_id1", 32'(d_id[1]), 32'd1); confere("d28_s1", 32'(d_s[1]), 32'hC3);
        confere("d28_id2", 32'(d_id[2]), 32'd0); confere("d28_s2", 32'(d_s[2]), 32'h3C);
`endif
        repeat (2) ciclo();

        // Single OR from requester 0.
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'hA0; req0_b = 8'h0F;
        ciclo();
        confere("d27_ready0", 32'(o_r0), 32'd1);
        req0_valid = 1'b0;
        ciclo();
        confere("d27_valid", 32'(resp_valid), 32'd1);
        confere("d27_s", 32'(resp_s), 32'hAF);
        confere("d27_id", 32'(resp_id), 32'd0);
        repeat (2) ciclo();

        // NOT from requester 1, b ignored.
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 8'h55; req1_b = 8'hAA;
        ciclo();
        req1_valid = 1'b0;
        ciclo();
        confere("d30_s", 32'(resp_s), 32'hAA);
        confere("d30_id", 32'(resp_id), 32'd1);
        repeat (2) ciclo();

        // Asynchronous reset in the middle of execution.
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'h12; req0_b = 8'h34;
        ciclo();
        req0_valid = 1'b0;
        #2;
        req0_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        confere("rstx_ready0", 32'(req0_ready), 32'd0);
        confere("rstx_valid", 32'(resp_valid), 32'd0);
        confere("rstx_s", 32'(resp_s), 32'h00);
        confere("rstx_id", 32'(resp_id), 32'd0);
        confere("rstx_ocupado", 32'(ocupado), 32'd0);
        modelo_reset();
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) ciclo();

        // Backpressure: response held for five cycles with both requesters pending.
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'h5A; req1_b = 8'hFF;
        ciclo();
        req1_valid = 1'b0;
        ciclo();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ciclo();
            confere("d29_valid", 32'(o_rv), 32'd1);
            confere("d29_s", 32'(o_s), 32'hA5);
            confere("d29_id", 32'(o_id), 32'd1);
            confere("d29_ready0", 32'(o_r0), 32'd0);
            confere("d29_ready1", 32'(o_r1), 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (3) ciclo();

        // Random traffic with withdrawals and backpressure.
        for (int k = 0; k < 600; k++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op    = 2'($urandom_range(0, 3));
            req1_op    = 2'($urandom_range(0, 3));
            req0_a     = 8'($urandom);
            req0_b     = 8'($urandom);
            req1_a     = 8'($urandom);
            req1_b     = 8'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            ciclo();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Four-cycle execution instance: latency and busy flag.
        b_req0_valid = 1'b1; b_req0_op = 2'b00; b_req0_a = 8'hF0; b_req0_b = 8'h3C;
        #2;
        confere("b_ready0", 32'(b_req0_ready), 32'd1);
        confere("b_ready1", 32'(b_req1_ready), 32'd0);
        @(posedge clk);
        #1;
        b_req0_valid = 1'b0;
        lat = 1;
        while (!b_resp_valid && lat < 12) begin
            confere("b_ocupado", 32'(b_ocupado), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        confere("b_latency", 32'(lat), 32'(CICLOS_B + 1));
        confere("b_s", 32'(b_resp_s), 32'h30);
        confere("b_id", 32'(b_resp_id), 32'd0);
        confere("b_ocupado_resp", 32'(b_ocupado), 32'd1);
        b_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        confere("b_ocupado_free", 32'(b_ocupado), 32'd0);
        confere("b_valid_off", 32'(b_resp_valid), 32'd0);
        confere("b_s_hold", 32'(b_resp_s), 32'h30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
